mk_design_multi: RTL

Parametrised successor to the fixed three-channel, 5-bit `XYZ_i` design. It provides `N_CH` independent channels, each with a per-channel operand FIFO of depth `DEPTH`. Each channel exposes three methods, flattened into per-channel bus slices:

- `start(a,b)`: enqueue an operand pair.
- `result(c)`: value method; peeks at the queue head.
- `check(d)`: actionvalue method; dequeues the head.

Each channel also exposes an occupancy count and a sticky protocol-error flag. It sits behind the same testbench harness as the fixed-size design.

---
 rtl/mk_design_multi_pkg.sv | 25 ++
 rtl/mk_design_multi_chan.sv | 91 +++++++++
 rtl/mk_design_multi.sv | 50 +++++
 3 files changed

// File: rtl/mk_design_multi_pkg.sv
// Shared definitions for the multi-channel start/result/check queue block.
// Compute helpers work on a wide word; callers truncate to their own WIDTH (WIDTH <= MAXW).
package mk_design_multi_pkg;

    localparam int MAXW = 64;

    typedef logic [MAXW-1:0] word_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic word_t calc_result(input word_t a, input word_t b, input word_t c);
        return a + b + c;
    endfunction

    function automatic word_t calc_check(input word_t a, input word_t b, input word_t d);
        return a ^ b ^ d;
    endfunction

endpackage

// File: rtl/mk_design_multi_chan.sv
// One channel: operand FIFO with peek/compute outputs, dequeue-on-check and a sticky error flag.
module mk_design_multi_chan
    import mk_design_multi_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] start_a,
    input  logic [WIDTH-1:0] start_b,
    input  logic             en_start,
    output logic             rdy_start,
    input  logic [WIDTH-1:0] result_c,
    output logic [WIDTH-1:0] res_val,
    output logic             rdy_result,
    input  logic [WIDTH-1:0] check_d,
    input  logic             en_check,
    output logic [WIDTH-1:0] chk_val,
    output logic             rdy_check,
    output logic [CW-1:0]    count,
    output logic             err
);

    localparam int PW = ptr_width(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    pair_t         mem [DEPTH];
    pair_t         head;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    // Readiness comes only from registered occupancy, so there is no bypass either way.
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = en_start && !full;
    assign do_pop  = en_check && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            cnt   <= cnt + CW'(do_push) - CW'(do_pop);
            err_q <= err_q | (en_start && full) | (en_check && empty);
        end
    end

    // Storage needs no reset: entries are only visible between valid pointers.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wptr] <= {start_a, start_b};
        end
    end

    always_comb begin
        res_val = '0;
        chk_val = '0;
        if (!empty) begin
            res_val = WIDTH'(calc_result(MAXW'(head.a), MAXW'(head.b), MAXW'(result_c)));
            chk_val = WIDTH'(calc_check(MAXW'(head.a), MAXW'(head.b), MAXW'(check_d)));
        end
    end

    assign rdy_start  = !full;
    assign rdy_result = !empty;
    assign rdy_check  = !empty;
    assign count      = cnt;
    assign err        = err_q;

endmodule

// File: rtl/mk_design_multi.sv
// N_CH independent start/result/check channels flattened onto per-channel bus slices.
module mk_design_multi
    import mk_design_multi_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_CH*WIDTH-1:0] XYZ_start_a,
    input  logic [N_CH*WIDTH-1:0] XYZ_start_b,
    input  logic [N_CH-1:0]       EN_XYZ_start,
    output logic [N_CH-1:0]       RDY_XYZ_start,
    input  logic [N_CH*WIDTH-1:0] XYZ_result_c,
    output logic [N_CH*WIDTH-1:0] XYZ_result,
    output logic [N_CH-1:0]       RDY_XYZ_result,
    input  logic [N_CH*WIDTH-1:0] XYZ_check_d,
    input  logic [N_CH-1:0]       EN_XYZ_check,
    output logic [N_CH*WIDTH-1:0] XYZ_check,
    output logic [N_CH-1:0]       RDY_XYZ_check,
    output logic [N_CH*CW-1:0]    XYZ_count,
    output logic [N_CH-1:0]       XYZ_err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        mk_design_multi_chan #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RST_N),
            .start_a   (XYZ_start_a[i*WIDTH +: WIDTH]),
            .start_b   (XYZ_start_b[i*WIDTH +: WIDTH]),
            .en_start  (EN_XYZ_start[i]),
            .rdy_start (RDY_XYZ_start[i]),
            .result_c  (XYZ_result_c[i*WIDTH +: WIDTH]),
            .res_val   (XYZ_result[i*WIDTH +: WIDTH]),
            .rdy_result(RDY_XYZ_result[i]),
            .check_d   (XYZ_check_d[i*WIDTH +: WIDTH]),
            .en_check  (EN_XYZ_check[i]),
            .chk_val   (XYZ_check[i*WIDTH +: WIDTH]),
            .rdy_check (RDY_XYZ_check[i]),
            .count     (XYZ_count[i*CW +: CW]),
            .err       (XYZ_err[i])
        );
    end

endmodule
